// File: rtl/tank_shell.sv
// tank_shell: player projectile that spawns at the barrel on a fire-key edge,
// flies one step per frame and then reloads. Define TANK_SHELL_BOUNCE_EN for one edge bounce.
module tank_shell #(
    parameter logic [7:0] FIRE_KEY        = 8'h2C,
    parameter int         SHELL_STEP      = 4,
    parameter int         BARREL          = 8,
    parameter int         SHELL_SIZE      = 2,
    parameter int         COOLDOWN_FRAMES = 30,
    parameter int         X_MIN           = 1,
    parameter int         X_MAX           = 639,
    parameter int         Y_MIN           = 1,
    parameter int         Y_MAX           = 479
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [1:0] direction,
    input  logic       hit,
    output logic [9:0] ShellX,
    output logic [9:0] ShellY,
    output logic [9:0] ShellS,
    output logic       shell_active,
    output logic [1:0] shell_dir,
    output logic [7:0] shots_fired
);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    localparam logic [9:0] STEP   = 10'(SHELL_STEP);
    localparam logic [9:0] BAR    = 10'(BARREL);
    localparam logic [9:0] TL_LIM = 10'(X_MIN + BARREL);
    localparam logic [9:0] TR_LIM = 10'(X_MAX - BARREL);
    localparam logic [9:0] TD_LIM = 10'(Y_MAX - BARREL);
    localparam logic [9:0] TU_LIM = 10'(Y_MIN + BARREL);
    localparam logic [9:0] SL_LIM = 10'(X_MIN + SHELL_STEP);
    localparam logic [9:0] SR_LIM = 10'(X_MAX - SHELL_STEP);
    localparam logic [9:0] SD_LIM = 10'(Y_MAX - SHELL_STEP);
    localparam logic [9:0] SU_LIM = 10'(Y_MIN + SHELL_STEP);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES - 1);

    localparam logic [1:0] D_LEFT  = 2'b00;
    localparam logic [1:0] D_RIGHT = 2'b01;
    localparam logic [1:0] D_DOWN  = 2'b10;
    localparam logic [1:0] D_UP    = 2'b11;

    typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

    state_t        state_q, state_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          active_q, active_d;
    logic [1:0]    dir_q, dir_d;
    logic [7:0]    shots_q, shots_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fire_prev_q, fire_prev_d;
`ifdef TANK_SHELL_BOUNCE_EN
    logic          bounced_q, bounced_d;
`endif

    logic       fire_now, fire_edge, launch_ok, oob, retire;
    logic [9:0] spawn_x, spawn_y, step_x, step_y;

    always_comb begin
        fire_now    = (keycode == FIRE_KEY);
        fire_edge   = fire_now & ~fire_prev_q;
        fire_prev_d = fire_now;

        // Limits are pre-offset constants so no operand can wrap.
        launch_ok = 1'b0;
        spawn_x   = TankX;
        spawn_y   = TankY;
        unique case (direction)
            D_LEFT:  begin launch_ok = TankX >= TL_LIM; spawn_x = TankX - BAR; end
            D_RIGHT: begin launch_ok = TankX <= TR_LIM; spawn_x = TankX + BAR; end
            D_DOWN:  begin launch_ok = TankY <= TD_LIM; spawn_y = TankY + BAR; end
            D_UP:    begin launch_ok = TankY >= TU_LIM; spawn_y = TankY - BAR; end
        endcase

        oob    = 1'b0;
        step_x = x_q;
        step_y = y_q;
        unique case (dir_q)
            D_LEFT:  begin oob = x_q < SL_LIM; step_x = x_q - STEP; end
            D_RIGHT: begin oob = x_q > SR_LIM; step_x = x_q + STEP; end
            D_DOWN:  begin oob = y_q > SD_LIM; step_y = y_q + STEP; end
            D_UP:    begin oob = y_q < SU_LIM; step_y = y_q - STEP; end
        endcase

        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        active_d  = active_q;
        dir_d     = dir_q;
        shots_d   = shots_q;
        cnt_d     = cnt_q;
        retire    = 1'b0;
`ifdef TANK_SHELL_BOUNCE_EN
        bounced_d = bounced_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (fire_edge && launch_ok) begin
                    state_d   = FLYING;
                    x_d       = spawn_x;
                    y_d       = spawn_y;
                    dir_d     = direction;
                    active_d  = 1'b1;
                    shots_d   = shots_q + 8'd1;
`ifdef TANK_SHELL_BOUNCE_EN
                    bounced_d = 1'b0;
`endif
                end
            end
            FLYING: begin
                if (hit) begin
                    retire = 1'b1;
                end else if (oob) begin
`ifdef TANK_SHELL_BOUNCE_EN
                    if (bounced_q) begin
                        retire = 1'b1;
                    end else begin
                        dir_d     = {dir_q[1], ~dir_q[0]};
                        bounced_d = 1'b1;
                    end
`else
                    retire = 1'b1;
`endif
                end else begin
                    x_d = step_x;
                    y_d = step_y;
                end
            end
            COOLDOWN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (retire) begin
            state_d  = COOLDOWN;
            active_d = 1'b0;
            cnt_d    = CD_LOAD;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            active_q    <= 1'b0;
            dir_q       <= 2'b00;
            shots_q     <= '0;
            cnt_q       <= '0;
            fire_prev_q <= 1'b0;
`ifdef TANK_SHELL_BOUNCE_EN
            bounced_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            active_q    <= active_d;
            dir_q       <= dir_d;
            shots_q     <= shots_d;
            cnt_q       <= cnt_d;
            fire_prev_q <= fire_prev_d;
`ifdef TANK_SHELL_BOUNCE_EN
            bounced_q   <= bounced_d;
`endif
        end
    end

    assign ShellX       = x_q;
    assign ShellY       = y_q;
    assign ShellS       = 10'(SHELL_SIZE);
    assign shell_active = active_q;
    assign shell_dir    = dir_q;
    assign shots_fired  = shots_q;
endmodule

// File: tb/tb_tank_shell.sv
// tb_tank_shell: directed stimulus, per-cycle check against a frame-level model.
module tb_tank_shell;
    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [9:0] TankX, TankY;
    logic [1:0] direction;
    logic       hit;
    logic [9:0] ShellX, ShellY, ShellS;
    logic       shell_active;
    logic [1:0] shell_dir;
    logic [7:0] shots_fired;

    int checks = 0;
    int errors = 0;

    always #5 frame_clk = ~frame_clk;

    tank_shell dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .TankX(TankX), .TankY(TankY), .direction(direction), .hit(hit),
        .ShellX(ShellX), .ShellY(ShellY), .ShellS(ShellS),
        .shell_active(shell_active), .shell_dir(shell_dir),
        .shots_fired(shots_fired)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 flying, 2 reloading with m_cd frames left.
    int m_mode, m_x, m_y, m_dir, m_shots, m_cd;
    bit m_prev, m_bnc, m_valid;

    function automatic bit in_field(int d, int x, int y);
        if (d < 2) return (x >= 1) && (x <= 639);
        return (y >= 1) && (y <= 479);
    endfunction

    function automatic int dx(int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction

    function automatic int dy(int d);
        return (d == 2) ? 1 : (d == 3) ? -1 : 0;
    endfunction

    always @(posedge frame_clk) begin : model
        bit fire, fedge;
        int nx, ny, d;
        fire  = (keycode == 8'h2C);
        fedge = fire && !m_prev;
        if (Reset) begin
            m_mode = 0; m_x = 0; m_y = 0; m_dir = 0;
            m_shots = 0; m_cd = 0; m_bnc = 0; m_valid = 1;
            m_prev = 0;
        end else begin
            case (m_mode)
                0: begin
                    d  = int'(direction);
                    nx = int'(TankX) + 8 * dx(d);
                    ny = int'(TankY) + 8 * dy(d);
                    if (fedge && in_field(d, nx, ny)) begin
                        m_mode = 1; m_x = nx; m_y = ny; m_dir = d;
                        m_shots = (m_shots + 1) % 256; m_bnc = 0;
                    end
                end
                1: begin
                    nx = m_x + 4 * dx(m_dir);
                    ny = m_y + 4 * dy(m_dir);
                    if (hit) begin
                        m_mode = 2; m_cd = 30;
                    end else if (!in_field(m_dir, nx, ny)) begin
`ifdef TANK_SHELL_BOUNCE_EN
                        if (!m_bnc) begin
                            m_dir = m_dir ^ 1; m_bnc = 1;
                        end else begin
                            m_mode = 2; m_cd = 30;
                        end
`else
                        m_mode = 2; m_cd = 30;
`endif
                    end else begin
                        m_x = nx; m_y = ny;
                    end
                end
                default: begin
                    m_cd = m_cd - 1;
                    if (m_cd == 0) m_mode = 0;
                end
            endcase
            m_prev = fire;
        end
    end

    always @(negedge frame_clk) begin
        if (m_valid) begin
            chk("ShellX", int'(ShellX), m_x);
            chk("ShellY", int'(ShellY), m_y);
            chk("active", int'(shell_active), int'(m_mode == 1));
            chk("dir", int'(shell_dir), m_dir);
            chk("shots", int'(shots_fired), m_shots);
            chk("ShellS", int'(ShellS), 2);
        end
    end

    task automatic cyc();
        @(posedge frame_clk);
        #2;
    endtask

    task automatic do_reset();
        Reset = 1'b1; keycode = 8'h00; hit = 1'b0;
        cyc();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; keycode = 8'h00; hit = 1'b0;
        TankX = 10'd0; TankY = 10'd0; direction = 2'b00;
        cyc(); cyc();
        chk("rst_active", int'(shell_active), 0);
        chk("rst_shots", int'(shots_fired), 0);
        chk("rst_x", int'(ShellX), 0);
        Reset = 1'b0;

        // Launch right and travel; tank moves afterwards but is ignored.
        TankX = 10'd160; TankY = 10'd240; direction = 2'b01;
        keycode = 8'h2C; cyc();
        chk("launch_x", int'(ShellX), 168);
        chk("launch_y", int'(ShellY), 240);
        chk("launch_act", int'(shell_active), 1);
        chk("launch_shots", int'(shots_fired), 1);
        keycode = 8'h00; direction = 2'b00; TankX = 10'd0;
        cyc(); chk("travel_1", int'(ShellX), 172);
        cyc(); chk("travel_2", int'(ShellX), 176);
        repeat (160) cyc();

        // Held key gives a single shot.
        do_reset();
        TankX = 10'd320; TankY = 10'd240; direction = 2'b11;
        keycode = 8'h2C;
        repeat (100) cyc();
        chk("hold_shots", int'(shots_fired), 1);
        keycode = 8'h00; cyc();
        keycode = 8'h2C; cyc();
        chk("repress_shots", int'(shots_fired), 2);
        keycode = 8'h00;
        repeat (100) cyc();

        // Left edge retire, then reload window.
        do_reset();
        TankX = 10'd20; TankY = 10'd100; direction = 2'b00;
        keycode = 8'h2C; cyc(); chk("left_1", int'(ShellX), 12);
        keycode = 8'h00; cyc(); chk("left_2", int'(ShellX), 8);
        cyc(); chk("left_3", int'(ShellX), 4);
        cyc();
        chk("left_ret_act", int'(shell_active), 0);
        chk("left_ret_x", int'(ShellX), 4);
        for (int i = 1; i <= 30; i++) begin
            keycode = (i % 2 == 1) ? 8'h2C : 8'h00;
            cyc();
            chk("reload_block", int'(shell_active), 0);
        end
        keycode = 8'h2C; cyc();
        chk("reload_fire", int'(shell_active), 1);
        chk("reload_shots", int'(shots_fired), 2);
        keycode = 8'h00;
        repeat (5) cyc();

        // Hit retires immediately; reset during reload aborts.
        do_reset();
        TankX = 10'd100; TankY = 10'd200; direction = 2'b11;
        keycode = 8'h2C; cyc(); chk("up_1", int'(ShellY), 192);
        keycode = 8'h00; cyc(); chk("up_2", int'(ShellY), 188);
        hit = 1'b1; cyc();
        chk("hit_act", int'(shell_active), 0);
        chk("hit_y", int'(ShellY), 188);
        hit = 1'b0;
        repeat (29) cyc();
        keycode = 8'h2C; cyc();
        chk("hit_cd_end", int'(shell_active), 0);
        keycode = 8'h00; cyc();
        keycode = 8'h2C; cyc();
        chk("hit_relaunch", int'(shell_active), 1);
        keycode = 8'h00; cyc();
        hit = 1'b1; cyc(); hit = 1'b0;
        repeat (10) cyc();
        Reset = 1'b1; cyc(); Reset = 1'b0;
        chk("abort_x", int'(ShellX), 0);
        chk("abort_y", int'(ShellY), 0);
        chk("abort_dir", int'(shell_dir), 0);
        chk("abort_shots", int'(shots_fired), 0);
        chk("abort_act", int'(shell_active), 0);

        // Launch guard.
        TankX = 10'd5; TankY = 10'd100; direction = 2'b00;
        keycode = 8'h2C; cyc();
        chk("guard_act", int'(shell_active), 0);
        chk("guard_shots", int'(shots_fired), 0);
        keycode = 8'h00; TankX = 10'd160; cyc();
        keycode = 8'h2C; cyc();
        chk("guard_ok_x", int'(ShellX), 152);
        chk("guard_ok_shots", int'(shots_fired), 1);
        keycode = 8'h00;

        // Right edge: bounce or retire.
        do_reset();
        TankX = 10'd620; TankY = 10'd240; direction = 2'b01;
        keycode = 8'h2C; cyc(); chk("right_1", int'(ShellX), 628);
        keycode = 8'h00; cyc(); chk("right_2", int'(ShellX), 632);
        cyc(); chk("right_3", int'(ShellX), 636);
        cyc();
        chk("edge_x", int'(ShellX), 636);
`ifdef TANK_SHELL_BOUNCE_EN
        chk("bounce_act", int'(shell_active), 1);
        chk("bounce_dir", int'(shell_dir), 0);
        repeat (158) cyc();
        chk("bounce_end_x", int'(ShellX), 4);
        chk("bounce_end_act", int'(shell_active), 1);
        cyc();
        chk("bounce_ret_act", int'(shell_active), 0);
        chk("bounce_ret_x", int'(ShellX), 4);
`else
        chk("edge_act", int'(shell_active), 0);
`endif
        repeat (35) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tank_shell.md
Name: tank_shell

Overview:
- Consumer of the player tank's position/direction outputs and the keyboard keycode.
- Spawns one projectile (shell) at the tank's barrel on a fire-key press and advances it once per frame in the tank's facing direction.
- Retires the shell at the playfield edge or on a collision hit, then enforces a reload cooldown.
- Feeds the sprite/colour mapper and collision logic.

Parameters:
- FIRE_KEY, 8'h2C, keycode that fires (space).
- SHELL_STEP, 4, pixels moved per frame.
- BARREL, 8, spawn offset from tank centre along facing direction.
- SHELL_SIZE, 2, shell half-size reported on ShellS.
- COOLDOWN_FRAMES, 30, frames spent in COOLDOWN; must be >= 1.
- X_MIN, 1; X_MAX, 639; Y_MIN, 1; Y_MAX, 479: playfield bounds, inclusive.

Ports:
- frame_clk  in  1  frame clock; one tick per video frame.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8  current keyboard keycode.
- TankX  in  10  tank centre X.
- TankY  in  10  tank centre Y.
- direction  in  2  tank facing: 00 left, 01 right, 10 down, 11 up.
- hit  in  1  collision logic reports shell impact this frame.
- ShellX  out  10  shell centre X.
- ShellY  out  10  shell centre Y.
- ShellS  out  10  constant SHELL_SIZE.
- shell_active  out  1  shell in flight (draw/collide enable).
- shell_dir  out  2  latched flight direction, same encoding as direction.
- shots_fired  out  8  count of successful launches; wraps 255 -> 0.

Behaviour:
- Clock and reset: single clock frame_clk; Reset is synchronous and active-high, sampled on posedge frame_clk.
- Reset values: state=IDLE, ShellX=0, ShellY=0, shell_active=0, shell_dir=00, shots_fired=0, cooldown counter=0, fire_prev=0, bounced=0. Reset mid-flight or mid-cooldown aborts immediately to these values.
- Fire edge:
  - fire_now = (keycode == FIRE_KEY); fire_prev <= fire_now every cycle in every state.
  - fire_edge = fire_now & ~fire_prev.
  - Holding the key yields one edge; a second shot requires release and re-press.
- States: IDLE, FLYING, COOLDOWN.
- IDLE:
  - On fire_edge, check the launch guard. Reject (stay IDLE, no count, no cooldown) if:
    - dir 00 and TankX < X_MIN+BARREL
    - dir 01 and TankX+BARREL > X_MAX
    - dir 10 and TankY+BARREL > Y_MAX
    - dir 11 and TankY < Y_MIN+BARREL
  - Otherwise, in the same edge: ShellX/ShellY <= tank centre offset by BARREL along direction; shell_dir <= direction; shell_active <= 1; shots_fired++; bounced <= 0; go to FLYING.
  - Latency: outputs valid one edge after the fire key is first sampled.
- FLYING, evaluated every edge, in priority order:
  1. hit=1 -> COOLDOWN.
  2. Out of bounds -> COOLDOWN. The test for the next step is:
     - dir 00: ShellX < X_MIN+SHELL_STEP
     - dir 01: ShellX+SHELL_STEP > X_MAX
     - dir 10: ShellY+SHELL_STEP > Y_MAX
     - dir 11: ShellY < Y_MIN+SHELL_STEP
  3. Otherwise move by SHELL_STEP along shell_dir.
  - Entering COOLDOWN: shell_active <= 0; position held (no wrap, no underflow); counter <= COOLDOWN_FRAMES-1.
  - hit and bound violation in the same frame are handled as hit (identical outcome).
  - The tank's direction, TankX and TankY are ignored after launch. fire_edge is ignored.
- COOLDOWN:
  - If counter == 0, go to IDLE; else decrement. Total time in COOLDOWN is COOLDOWN_FRAMES edges.
  - fire_edge is ignored; fire_prev keeps tracking.
  - hit is ignored.
- Arithmetic: all 10-bit unsigned. Bound comparisons are formed so that no operand underflows or overflows.

Optional Feature:
- Macro: TANK_SHELL_BOUNCE_EN.
- Defined: the first out-of-bounds condition in FLYING with bounced=0 does not retire the shell. Instead:
  - shell_dir flips (00<->01, 10<->11);
  - position is held that frame;
  - bounced <= 1.
  - A second violation retires the shell as normal. hit still retires immediately.
- Undefined: the bounced register is absent; the first violation retires the shell.

Test Plan:
- Launch and travel: Reset; TankX=160, TankY=240, direction=01; keycode=2C for one frame -> ShellX=168, ShellY=240, shell_active=1, shots_fired=1. Next edges -> ShellX=172, 176.
- Hold fire: hold keycode=2C for 100 frames, tank at 320,240, dir=11 -> exactly one launch (shots_fired=1). Release, wait past cooldown, re-press -> shots_fired=2.
- Left edge retire: TankX=20, dir=00, fire -> ShellX sequence 12, 8, 4. At the next edge shell_active=0 with ShellX held at 4. Fire edges during the following 30 frames are ignored; a press at frame 31 launches.
- Hit: launch upward from (100,200); assert hit on the 3rd flying frame -> shell_active=0 at that edge; COOLDOWN lasts 30 edges. Reset asserted mid-cooldown -> all outputs at reset values the next edge.
- Launch guard: TankX=5, dir=00, fire -> stays IDLE, shell_active=0, shots_fired unchanged, and an immediate re-press with TankX=160 launches.
- With TANK_SHELL_BOUNCE_EN: TankX=620, dir=01, fire -> ShellX 628, 632, 636. Next edge: dir becomes 00 and ShellX stays 636. Shell then travels left to ShellX=4 and retires. Without the macro, it retires at 636.
